// File: rtl/periph_link_pkg.sv
// periph_link_pkg: shared FSM states, line levels and parity helper for the periphery return link
package periph_link_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic PARITY_ODD = 1'b1;
  localparam int MAX_IN = 16;
  function automatic logic odd_parity(input logic [MAX_IN-1:0] v);
    return PARITY_ODD ^ (^v);
  endfunction
endpackage

// File: rtl/input_debounce.sv
// input_debounce: two-flop synchroniser plus run-length debounce for one periphery pin
module input_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic deb_out
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic sync1_q, sync2_q, deb_q, deb_d, diff, done;
  logic [CW-1:0] cnt_q, cnt_d;
  assign diff = sync2_q != deb_q;
  assign done = cnt_q == CW'(DEB_CYCLES - 1);
  assign deb_out = deb_q;
  // a new level is accepted only after DEB_CYCLES consecutive differing samples
  always_comb begin
    deb_d = (diff && done) ? sync2_q : deb_q;
    cnt_d = (diff && !done) ? cnt_q + 1'b1 : '0;
  end
  // synchroniser chain and debounce state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/periph_return_tx.sv
// periph_return_tx: debounces periphery pins and reports each accepted change as a UART-style frame
module periph_return_tx
  import periph_link_pkg::*;
#(
  parameter int N_IN = 8,
  parameter int DEB_CYCLES = 16,
  parameter int BIT_DIV = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] periph_in,
  input  logic            tx_enable,
  output logic            tx_line,
  output logic            busy,
  output logic [7:0]      frame_cnt,
  output logic [N_IN-1:0] deb_value
);
  localparam int CW = $clog2(BIT_DIV);
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N_IN-1:0] shift_q, shift_d, last_q, last_d, shift_nx;
  logic tx_q, tx_d, busy_q, busy_d, bit_end, last_bit;
  logic [7:0] fcnt_q, fcnt_d;
  genvar i;
  generate
    for (i = 0; i < N_IN; i++) begin : g_deb
      input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk(clk), .rst(rst), .raw_in(periph_in[i]), .deb_out(deb_value[i])
      );
    end
  endgenerate
  assign tx_line = tx_q;
  assign busy = busy_q;
  assign frame_cnt = fcnt_q;
  assign bit_end = cnt_q == CW'(BIT_DIV - 1);
  assign last_bit = idx_q == IW'(N_IN - 1);
  assign shift_nx = shift_q >> 1;
  // frame sequencing: next state and next line level are decided together so tx_line is registered
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    shift_d = shift_q;
    last_d = last_q;
    tx_d = tx_q;
    busy_d = busy_q;
    fcnt_d = fcnt_q;
    if (state_q == IDLE) begin
      if (tx_enable && deb_value != last_q) begin
        state_d = START;
        shift_d = deb_value;
        last_d = deb_value;
        tx_d = START_LEVEL;
        busy_d = 1'b1;
        cnt_d = '0;
      end
    end else begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      if (bit_end) begin
        case (state_q)
          START: begin
            state_d = DATA;
            idx_d = '0;
            tx_d = shift_q[0];
          end
          DATA: begin
            state_d = last_bit ? PARITY : DATA;
            idx_d = last_bit ? idx_q : idx_q + 1'b1;
            shift_d = shift_nx;
            tx_d = last_bit ? odd_parity(MAX_IN'(last_q)) : shift_nx[0];
          end
          PARITY: begin
            state_d = STOP;
            tx_d = STOP_LEVEL;
          end
          STOP: begin
            state_d = IDLE;
            tx_d = IDLE_LEVEL;
            busy_d = 1'b0;
            fcnt_d = fcnt_q + 8'd1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end
  // FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      last_q <= '0;
      tx_q <= IDLE_LEVEL;
      busy_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      last_q <= last_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      fcnt_q <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_periph_return_tx.sv
// tb_periph_return_tx: scoreboard bench decoding the serial line against an expected-frame queue
module tb_periph_return_tx;
  localparam int N = 8, DEB = 4, BD = 4, FL = (N + 3) * BD;
  logic clk = 1'b0, rst = 1'b1, tx_enable = 1'b1;
  logic [N-1:0] periph_in = '1;
  logic tx_line, busy;
  logic [7:0] frame_cnt;
  logic [N-1:0] deb_value;
  int n_vec = 0, n_err = 0, exp_cnt = 0, lat = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] sent = '0, v, g;

  always #5 clk = ~clk;

  periph_return_tx #(.N_IN(N), .DEB_CYCLES(DEB), .BIT_DIV(BD)) dut (
    .clk(clk), .rst(rst), .periph_in(periph_in), .tx_enable(tx_enable),
    .tx_line(tx_line), .busy(busy), .frame_cnt(frame_cnt), .deb_value(deb_value)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] val);
    @(negedge clk);
    periph_in = val;
    if (val != sent) begin
      exp_q.push_back(val);
      sent = val;
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    idle(3);
    check("drain_pending", exp_q.size(), 0);
  endtask

  // monitor: decode one frame per falling edge, compare with the oldest expected value
  initial begin
    logic [N+2:0] bits, eb;
    logic [N-1:0] e;
    bit ok, ab;
    forever begin
      @(negedge clk);
      if (!rst && tx_line == 1'b0) begin
        ok = 1'b1;
        ab = 1'b0;
        bits = '0;
        for (int k = 0; k < FL; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            ab = 1'b1;
            break;
          end
          if (k % BD == 0) bits[k / BD] = tx_line;
          else if (tx_line !== bits[k / BD]) ok = 1'b0;
          if (busy !== 1'b1) ok = 1'b0;
        end
        if (!ab) begin
          @(negedge clk);
          check("bit_shape", ok, 1);
          check("frame_queue_size_nonzero", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            eb = {1'b1, ($countones(e) % 2 == 0) ? 1'b1 : 1'b0, e, 1'b0};
            check("frame_bits", bits, eb);
            exp_cnt++;
          end
          if (!rst) begin
            check("frame_cnt", frame_cnt, exp_cnt % 256);
            check("idle_gap", {busy, tx_line}, 2'b01);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    idle(3);
    check("rst_tx", tx_line, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_deb", deb_value, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.push_back(8'hFF);
    sent = 8'hFF;
    drain();
    drive(8'h00);
    drain();
    drive(8'hA5);
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (!tx_line) begin
        lat = c;
        break;
      end
    end
    check("start_latency_7_to_9", lat >= 7 && lat <= 9, 1);
    drain();
    drive(8'h00);
    drain();
    @(negedge clk);
    periph_in = 8'h01;
    idle(2);
    periph_in = 8'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("glitch_deb", deb_value, 0);
      check("glitch_tx", tx_line, 1);
    end
    for (int i = 0; i < 15; i++) begin
      v = N'($urandom);
      g = N'($urandom);
      @(negedge clk);
      periph_in = sent ^ g;
      idle(2);
      periph_in = sent;
      idle(3);
      drive(v);
      drain();
    end
    drive(8'h00);
    drain();
    drive(8'h01);
    idle(20);
    drive(8'h03);
    drain();
    drive(8'h00);
    drain();
    drive(8'h01);
    idle(20);
    periph_in = 8'h00;
    idle(12);
    periph_in = 8'h01;
    drain();
    @(negedge clk);
    tx_enable = 1'b0;
    periph_in = 8'h10;
    idle(20);
    periph_in = 8'h30;
    idle(20);
    check("disabled_deb", deb_value, 8'h30);
    check("disabled_busy", busy, 0);
    tx_enable = 1'b1;
    exp_q.push_back(8'h30);
    sent = 8'h30;
    drain();
    drive(8'h5A);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!tx_line) break;
    end
    check("reset_frame_started", tx_line, 0);
    idle(10);
    check("mid_frame_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", tx_line, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_cnt", frame_cnt, 0);
    check("async_rst_deb", deb_value, 0);
    exp_q.delete();
    exp_cnt = 0;
    idle(3);
    #2 rst = 1'b0;
    exp_q.push_back(8'h5A);
    sent = 8'h5A;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/periph_return_tx.md
Name: periph_return_tx

Overview:
- Return-path transmitter on the periphery connector: carries periphery-side input pins back to the FPGA connector over one pin, opposite to the existing straight FPGA-to-periphery routing.
- Synchronises and debounces N_IN periphery inputs.
- On any accepted change, sends one UART-style frame (start, data, parity, stop) on a single FPGA-side pin.
- Lets the FPGA board read many periphery lines through one routed pin.

Parameters:
- N_IN, 8, number of periphery input lines, legal 1..16.
- DEB_CYCLES, 16, consecutive equal synchronised samples needed to accept a new level, legal >=1.
- BIT_DIV, 8, clk cycles per transmitted bit, legal >=2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- periph_in  in  N_IN  raw periphery pins, asynchronous to clk.
- tx_enable  in  1  permits starting new frames.
- tx_line  out  1  serial line to FPGA-side pin, idle high.
- busy  out  1  high from START entry to last STOP cycle.
- frame_cnt  out  8  frames completed, modulo 256.
- deb_value  out  N_IN  current debounced input vector.

Behaviour:
- Reset (async, immediate): tx_line=1, busy=0, frame_cnt=0, deb_value=0, last_sent=0, FSM=IDLE, all counters 0. This applies mid-frame too: the line returns high at once with no partial stop bit.
- Input path, per bit:
  - 2-FF synchroniser.
  - Debounce counter, reset to 0 whenever the synchronised sample equals the current debounced bit.
  - When the sample differs for DEB_CYCLES consecutive cycles, the debounced bit updates and the counter clears.
  - Shorter pulses are never accepted.
- Trigger: in IDLE with tx_enable=1 and deb_value != last_sent:
  - Latch shift_reg=deb_value and last_sent=deb_value.
  - Go to START on the next cycle.
- FSM, each bit state lasting exactly BIT_DIV cycles (bit counter 0..BIT_DIV-1):
  - IDLE: tx_line=1, busy=0.
  - START: tx_line=0.
  - DATA: tx_line=shift_reg[idx], idx 0..N_IN-1, LSB first.
  - PARITY: tx_line = odd parity, so the total count of ones in data plus parity is odd.
  - STOP: tx_line=1; on the last cycle frame_cnt increments (255 wraps to 0), then IDLE.
- Frame length: (N_IN+3)*BIT_DIV cycles.
- Latency from a stable periphery change to the START edge: 2 (sync) + DEB_CYCLES + 1 (latch) + 1 cycles, ±1.
- Changes during a frame:
  - Frame content is frozen; deb_value keeps tracking.
  - After STOP, the IDLE compare re-evaluates, giving at least one idle cycle before the next START.
  - A change that reverts to last_sent before the frame ends produces no extra frame.
- tx_enable=0 mid-frame: the current frame completes; no new frame starts until tx_enable=1, then the latest deb_value is sent (intermediate values are lost).
- All outputs are registered; no combinational path from periph_in to tx_line.

Decomposition:
- Package periph_link_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP}.
  - Constants: IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1, PARITY_ODD=1.
  - Function computing odd parity of a vector.
- Sub-module input_debounce: single bit with synchroniser and counter, parameter DEB_CYCLES, ports clk, rst, raw_in, deb_out. Instantiated N_IN times via generate.

Test Plan (N_IN=8, DEB_CYCLES=4, BIT_DIV=4):
- Reset: assert rst with periph_in=8'hFF -> tx_line=1, busy=0, frame_cnt=0, deb_value=0; release and hold -> one frame of 8'hFF, parity bit 1 (8 ones), frame_cnt=1.
- periph_in 0->8'hA5, held -> after ~8 cycles START for 4 cycles, then data 1,0,1,0,0,1,0,1 at 4 cycles each, parity 1, stop 1; total 44 cycles busy; frame_cnt=1.
- 2-cycle glitch to 8'h01 from 8'h00 -> deb_value stays 0, tx_line stays 1, no frame.
- Change 8'h03 during a frame of 8'h01 -> first frame completes unchanged; second frame carries 8'h03 (parity 1) after at least one idle cycle; frame_cnt=2.
- tx_enable=0, periph_in 8'h10 then 8'h30 -> no frame; tx_enable=1 -> a single frame of 8'h30.
- rst pulse during DATA of frame 8'h5A -> tx_line=1 the same cycle, busy=0, frame_cnt=0; after release, 8'h5A is retransmitted since last_sent=0.
